// File: rtl/mem_ctrl_if.sv
// Core-side request/response ports and the 8-bit system bus of mem_ctrl.
// The master modport is the pipeline/top side; the slave modport is the controller.
interface mem_ctrl_if;
  // Handshake: if_req/ls_req are level requests; the request is held with stable
  // fields until its done pulse. Done is a single-cycle pulse with the data valid
  // in that cycle. The requester drops req no later than the cycle after done.
  logic        rdy_in;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_wr;
  logic [1:0]  ls_size;
  logic        ls_sign;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [1:0]  fsm_state;

  modport master (
    output rdy_in, if_req, if_addr, ls_req, ls_wr, ls_size, ls_sign, ls_addr,
           ls_wdata, mem_din,
    input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr, fsm_state
  );

  modport slave (
    input  rdy_in, if_req, if_addr, ls_req, ls_wr, ls_size, ls_sign, ls_addr,
           ls_wdata, mem_din,
    output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr, fsm_state
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serialising memory controller: fetch and load/store ports share one 8-bit bus.
// Reads are pipelined (address one cycle ahead of data); writes are one byte per cycle.
module mem_ctrl (
  input  logic      clk_in,
  input  logic      rst_in,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

  state_t      state;
  logic [31:0] base;
  logic [31:0] wdata;
  logic [2:0]  n_bytes;
  logic [2:0]  issue_k;
  logic [2:0]  cap_k;
  logic [2:0]  wr_k;
  logic [23:0] rbuf;
  logic        is_ls;
  logic        sgn;
  logic        a_live;
  logic        cap_en;

  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [2:0] k);
    case (k[1:0])
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  // top is the last byte, still on mem_din when the final capture happens.
  function automatic logic [31:0] assemble(input logic [23:0] lo, input logic [7:0] top,
                                           input logic [2:0] n, input logic s);
    logic e;
    e = s & top[7];
    case (n)
      3'd1:    return {{24{e}}, top};
      3'd2:    return {{16{e}}, top, lo[7:0]};
      default: return {top, lo};
    endcase
  endfunction

  assign bus.fsm_state = state;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= IDLE;
      base         <= '0;
      wdata        <= '0;
      n_bytes      <= '0;
      issue_k      <= '0;
      cap_k        <= '0;
      wr_k         <= '0;
      rbuf         <= '0;
      is_ls        <= 1'b0;
      sgn          <= 1'b0;
      a_live       <= 1'b0;
      cap_en       <= 1'b0;
      bus.if_done  <= 1'b0;
      bus.if_data  <= '0;
      bus.ls_done  <= 1'b0;
      bus.ls_rdata <= '0;
      bus.mem_a    <= '0;
      bus.mem_dout <= '0;
      bus.mem_wr   <= 1'b0;
    end else begin
      bus.if_done <= 1'b0;
      bus.ls_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rdy_in && (bus.ls_req || bus.if_req)) begin
            is_ls     <= bus.ls_req;
            sgn       <= bus.ls_req & bus.ls_sign;
            n_bytes   <= bus.ls_req ? size_to_n(bus.ls_size) : 3'd4;
            base      <= bus.ls_req ? bus.ls_addr : bus.if_addr;
            wdata     <= bus.ls_wdata;
            bus.mem_a <= bus.ls_req ? bus.ls_addr : bus.if_addr;
            if (bus.ls_req && bus.ls_wr) begin
              state        <= WRITE;
              wr_k         <= 3'd0;
              bus.mem_wr   <= 1'b1;
              bus.mem_dout <= bus.ls_wdata[7:0];
            end else begin
              state   <= READ;
              issue_k <= 3'd1;
              cap_k   <= 3'd0;
              a_live  <= 1'b1;
              cap_en  <= 1'b0;
            end
          end
        end
        READ: begin
          if (!bus.rdy_in) begin
            // Bus belongs to HCI: in-flight data is lost, so restart at the first uncaptured byte.
            bus.mem_a <= base + {29'd0, cap_k};
            issue_k   <= cap_k + 3'd1;
            a_live    <= 1'b1;
            cap_en    <= 1'b0;
          end else if (cap_en && (cap_k == n_bytes - 3'd1)) begin
            state     <= DONE;
            a_live    <= 1'b0;
            cap_en    <= 1'b0;
            bus.mem_a <= '0;
            if (is_ls) begin
              bus.ls_done  <= 1'b1;
              bus.ls_rdata <= assemble(rbuf, bus.mem_din, n_bytes, sgn);
            end else begin
              bus.if_done <= 1'b1;
              bus.if_data <= assemble(rbuf, bus.mem_din, n_bytes, 1'b0);
            end
          end else begin
            if (cap_en) begin
              case (cap_k[1:0])
                2'd0:    rbuf[7:0]   <= bus.mem_din;
                2'd1:    rbuf[15:8]  <= bus.mem_din;
                default: rbuf[23:16] <= bus.mem_din;
              endcase
              cap_k <= cap_k + 3'd1;
            end
            cap_en <= a_live;
            if (issue_k < n_bytes) begin
              bus.mem_a <= base + {29'd0, issue_k};
              issue_k   <= issue_k + 3'd1;
              a_live    <= 1'b1;
            end else begin
              bus.mem_a <= '0;
              a_live    <= 1'b0;
            end
          end
        end
        WRITE: begin
          // mem_wr high here means the byte at wr_k was on the bus this cycle.
          if (!bus.rdy_in) begin
            bus.mem_wr <= 1'b0;
          end else if (bus.mem_wr) begin
            if (wr_k == n_bytes - 3'd1) begin
              state        <= DONE;
              bus.ls_done  <= 1'b1;
              bus.mem_wr   <= 1'b0;
              bus.mem_a    <= '0;
              bus.mem_dout <= '0;
            end else begin
              wr_k         <= wr_k + 3'd1;
              bus.mem_a    <= base + {29'd0, wr_k + 3'd1};
              bus.mem_dout <= byte_of(wdata, wr_k + 3'd1);
              bus.mem_wr   <= 1'b1;
            end
          end else begin
            bus.mem_a    <= base + {29'd0, wr_k};
            bus.mem_dout <= byte_of(wdata, wr_k);
            bus.mem_wr   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
